fft_frame_loader: RTL

- Drains one complete 512-sample frame from the SPI sample buffer, which is the 8-bit read port of the dual-port RAM written by the SPI loader, into the FFT working memory.
- Converts each 8-bit offset-binary sample to a signed BIT_WIDTH real part with a zero imaginary part.
- Writes results at bit-reversed addresses, so the in-place radix-2 FFT that follows can start directly on natural-order data.
- Sits between the SPI loader's buffer and the FFT core; the FFT controller pulses start when a frame is ready.

---
 rtl/fft_frame_loader_if.sv | 27 ++
 rtl/fft_frame_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_loader_if.sv
// Buffer-read, FFT-write and control signals of the frame loader.
// The loader drives the "master" side and its environment takes the "slave" side.
interface fft_frame_loader_if #(
  parameter int unsigned SPI_WIDTH = 8,
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned N         = 9
);
  logic                   start;
  logic                   buf_en_rd;
  logic [N-1:0]           buf_add_rd;
  logic [SPI_WIDTH-1:0]   buf_dout;
  logic                   fft_wr_en;
  logic [N-1:0]           fft_wr_addr;
  logic [2*BIT_WIDTH-1:0] fft_wr_data;
  logic                   busy;
  logic                   done;

  modport master (
    input  start, buf_dout,
    output buf_en_rd, buf_add_rd, fft_wr_en, fft_wr_addr, fft_wr_data, busy, done
  );

  modport slave (
    output start, buf_dout,
    input  buf_en_rd, buf_add_rd, fft_wr_en, fft_wr_addr, fft_wr_data, busy, done
  );
endinterface

// File: rtl/fft_frame_loader.sv
// Copies one 2^N-sample frame from the SPI buffer into FFT memory at bit-reversed addresses.
// Optional Hann window stage: define FFT_LOADER_HANN_WINDOW_EN.
module fft_frame_loader #(
  parameter int unsigned SPI_WIDTH = 8,
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned N         = 9,
  parameter int unsigned SHIFT     = 6
) (
  input  logic               sclk,
  input  logic               reset,
  fft_frame_loader_if.master bus
);
  localparam int unsigned FRAME = 1 << N;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           state, state_nxt;
  logic [N:0]           rd_idx, rd_idx_nxt;
  logic                 buf_en_q, buf_en_nxt;
  logic [N-1:0]         buf_add_q, buf_add_nxt;
  logic                 busy_q, busy_nxt;
  logic                 done_q, done_nxt;
  logic                 pipe_busy_c;

  logic                 s1_vld;
  logic [N-1:0]         s1_idx;

  logic                 src_vld_c;
  logic [N-1:0]         src_idx_c;
  logic [BIT_WIDTH-1:0] src_real_c;

  logic                 wr_en_q;
  logic [N-1:0]         wr_addr_q;
  logic [BIT_WIDTH-1:0] wr_real_q;

  function automatic logic [N-1:0] bit_rev(input logic [N-1:0] a);
    logic [N-1:0] r;
    for (int i = 0; i < int'(N); i++) r[i] = a[N-1-i];
    return r;
  endfunction

  // Offset-binary to two's complement, sign-extended and scaled.
  function automatic logic [BIT_WIDTH-1:0] conv(input logic [SPI_WIDTH-1:0] d);
    logic signed [SPI_WIDTH-1:0] c;
    logic signed [BIT_WIDTH-1:0] ext;
    c   = {~d[SPI_WIDTH-1], d[SPI_WIDTH-2:0]};
    ext = BIT_WIDTH'(c);
    return BIT_WIDTH'(ext <<< SHIFT);
  endfunction

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      rd_idx    <= '0;
      buf_en_q  <= 1'b0;
      buf_add_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_idx    <= rd_idx_nxt;
      buf_en_q  <= buf_en_nxt;
      buf_add_q <= buf_add_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rd_idx_nxt  = rd_idx;
    buf_en_nxt  = 1'b0;
    buf_add_nxt = buf_add_q;
    busy_nxt    = busy_q;
    done_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt   = S_READ;
          buf_en_nxt  = 1'b1;
          buf_add_nxt = '0;
          rd_idx_nxt  = (N+1)'(1);
          busy_nxt    = 1'b1;
        end
      end
      S_READ: begin
        if (rd_idx == (N+1)'(FRAME)) begin
          state_nxt = S_DRAIN;
        end else begin
          buf_en_nxt  = 1'b1;
          buf_add_nxt = rd_idx[N-1:0];
          rd_idx_nxt  = rd_idx + (N+1)'(1);
        end
      end
      S_DRAIN: begin
        // Done is registered, so it lands one cycle after the final write.
        if (!pipe_busy_c) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Stage 1: index tag for the word the RAM is returning.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_idx <= '0;
    end else begin
      s1_vld <= buf_en_q;
      if (buf_en_q) s1_idx <= buf_add_q;
    end
  end

`ifdef FFT_LOADER_HANN_WINDOW_EN
  typedef logic [15:0] coef_t [FRAME];

  function automatic coef_t hann_table();
    coef_t t;
    real   pi;
    real   w;
    pi = 3.14159265358979323846;
    for (int k = 0; k < int'(FRAME); k++) begin
      w    = 32767.0 * 0.5 * (1.0 - $cos(2.0 * pi * real'(k) / real'(FRAME)));
      t[k] = 16'($rtoi(w + 0.5));
    end
    return t;
  endfunction

  localparam coef_t HANN_ROM = hann_table();

  logic                        s2_vld;
  logic [N-1:0]                s2_idx;
  logic signed [BIT_WIDTH-1:0] s2_real;
  logic signed [BIT_WIDTH+16:0] prod_c;

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      s2_vld  <= 1'b0;
      s2_idx  <= '0;
      s2_real <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_idx  <= s1_idx;
        s2_real <= conv(bus.buf_dout);
      end
    end
  end

  // Q1.15 coefficient is unsigned, so widen it with a zero sign bit.
  always_comb begin
    prod_c      = (BIT_WIDTH+17)'(s2_real) * (BIT_WIDTH+17)'($signed({1'b0, HANN_ROM[s2_idx]}));
    src_vld_c   = s2_vld;
    src_idx_c   = s2_idx;
    src_real_c  = BIT_WIDTH'(prod_c >>> 15);
    pipe_busy_c = buf_en_q | s1_vld | s2_vld;
  end
`else
  always_comb begin
    src_vld_c   = s1_vld;
    src_idx_c   = s1_idx;
    src_real_c  = conv(bus.buf_dout);
    pipe_busy_c = buf_en_q | s1_vld;
  end
`endif

  // Output stage: address and data hold their last values between writes.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_real_q <= '0;
    end else begin
      wr_en_q <= src_vld_c;
      if (src_vld_c) begin
        wr_addr_q <= bit_rev(src_idx_c);
        wr_real_q <= src_real_c;
      end
    end
  end

  assign bus.buf_en_rd   = buf_en_q;
  assign bus.buf_add_rd  = buf_add_q;
  assign bus.fft_wr_en   = wr_en_q;
  assign bus.fft_wr_addr = wr_addr_q;
  assign bus.fft_wr_data = {wr_real_q, BIT_WIDTH'(0)};
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule
